shift_divider: RTL and testbench

SHIFT_DIVIDER -- requirements
Module: shift_divider

---
 rtl/shift_divider.sv | 181 ++++++++++++++++++
 tb/tb_shift_divider.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_divider.sv
// shift_divider -- multi-cycle restoring divider, one quotient bit per cycle.
//
// Parameters
//   BITS          operand/result width (>= 2)
// Ports
//   in_clk        clock; all state updates on the rising edge
//   in_rst        synchronous active-high reset
//   in_start      start request, honoured only in Idle or Finished
//   in_signed     two's-complement mode select, latched with in_start
//   in_a, in_b    dividend / divisor, latched with in_start
//   out_quot      registered quotient
//   out_rem       registered remainder
//   out_busy      operation in progress (from the cycle after acceptance)
//   out_finished  result valid, held until the next accepted start
//   out_divzero   divisor was zero for the current result
//
// Configuration macro
//   SHIFT_DIVIDER_SIGNED_EN  defined: in_signed honoured (truncating signed
//                            division); undefined: unsigned only, no sign logic.
module shift_divider #(
  parameter int BITS = 8
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic            in_signed,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  output logic [BITS-1:0] out_quot,
  output logic [BITS-1:0] out_rem,
  output logic            out_busy,
  output logic            out_finished,
  output logic            out_divzero
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREPARE,
    S_SHIFT,
    S_FIXUP,
    S_FINISHED
  } state_t;

  state_t          r_state;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [BITS-1:0] r_q;     // dividend shifting out / quotient shifting in
  logic [BITS-1:0] r_bmag;
  logic [BITS-1:0] r_rem;
  logic [CW-1:0]   r_cnt;
  logic            r_dz;

  logic [BITS:0]   w_trial; // BITS+1-bit partial remainder after the shift
  logic            w_ge;
  logic [BITS-1:0] w_diff;
  logic [BITS-1:0] w_a_mag;
  logic [BITS-1:0] w_b_mag;
  logic [BITS-1:0] w_q_fix;
  logic [BITS-1:0] w_r_fix;

`ifdef SHIFT_DIVIDER_SIGNED_EN
  logic r_sgn;
  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;
`else
  logic w_unused_signed;
  assign w_unused_signed = in_signed;
`endif

  // Restoring step. The subtraction result is always below the divisor
  // magnitude, so the low BITS bits of the difference are exact.
  always_comb begin
    w_trial = {r_rem, r_q[BITS-1]};
    w_ge    = (w_trial >= {1'b0, r_bmag});
    w_diff  = w_trial[BITS-1:0] - r_bmag;
  end

  always_comb begin
`ifdef SHIFT_DIVIDER_SIGNED_EN
    w_a_neg = r_sgn & r_a[BITS-1];
    w_b_neg = r_sgn & r_b[BITS-1];
    w_a_mag = w_a_neg ? (~r_a + 1'b1) : r_a;
    w_b_mag = w_b_neg ? (~r_b + 1'b1) : r_b;
    w_q_fix = r_neg_q ? (~r_q + 1'b1) : r_q;
    w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
`else
    w_a_mag = r_a;
    w_b_mag = r_b;
    w_q_fix = r_q;
    w_r_fix = r_rem;
`endif
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_q          <= '0;
      r_bmag       <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_dz         <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_busy     <= 1'b0;
      out_finished <= 1'b0;
      out_divzero  <= 1'b0;
`ifdef SHIFT_DIVIDER_SIGNED_EN
      r_sgn        <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_FINISHED: begin
          if (in_start) begin
            r_a          <= in_a;
            r_b          <= in_b;
`ifdef SHIFT_DIVIDER_SIGNED_EN
            r_sgn        <= in_signed;
`endif
            out_finished <= 1'b0;
            out_divzero  <= 1'b0;
            r_state      <= S_PREPARE;
          end
        end

        S_PREPARE: begin
          out_busy <= 1'b1;
          if (r_b == '0) begin
            // Divide-by-zero result is written here; the pass through Fixup
            // only supplies the one-cycle delay before out_finished rises.
            out_quot    <= '1;
            out_rem     <= r_a;
            out_divzero <= 1'b1;
            r_dz        <= 1'b1;
            r_state     <= S_FIXUP;
          end else begin
            r_q     <= w_a_mag;
            r_bmag  <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
`ifdef SHIFT_DIVIDER_SIGNED_EN
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
`endif
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_q   <= {r_q[BITS-2:0], w_ge};
          r_rem <= w_ge ? w_diff : w_trial[BITS-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(BITS - 1)) begin
            r_state <= S_FIXUP;
          end
        end

        S_FIXUP: begin
          if (!r_dz) begin
            out_quot <= w_q_fix;
            out_rem  <= w_r_fix;
          end
          out_finished <= 1'b1;
          out_busy     <= 1'b0;
          r_state      <= S_FINISHED;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_divider.sv
// tb_shift_divider -- table-driven and randomised checks of shift_divider
// (BITS = 8) using an expected-result queue, plus a reset-abort sequence.
module tb_shift_divider;

  localparam int BITS = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic            sgn;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic [BITS-1:0] quot;
  logic [BITS-1:0] rem;
  logic            busy;
  logic            finished;
  logic            divzero;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] prev_q;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  vec_t vecs [0:8];
  exp_t sb[$];

  shift_divider #(.BITS(BITS)) dut (
    .in_clk       (clk),
    .in_rst       (rst),
    .in_start     (start),
    .in_signed    (sgn),
    .in_a         (a),
    .in_b         (b),
    .out_quot     (quot),
    .out_rem      (rem),
    .out_busy     (busy),
    .out_finished (finished),
    .out_divzero  (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic ms,
                                output logic [7:0] mq, output logic [7:0] mr, output logic mdz);
    int   sa;
    int   sd;
    int   qi;
    int   ri;
    logic use_s;
`ifdef SHIFT_DIVIDER_SIGNED_EN
    use_s = ms;
`else
    use_s = ms & 1'b0;
`endif
    mdz = (mb == 8'd0);
    if (mb == 8'd0) begin
      mq = 8'hFF;
      mr = ma;
    end else if (use_s) begin
      sa = $signed(ma);
      sd = $signed(mb);
      qi = sa / sd;
      ri = sa % sd;
      mq = qi[7:0];
      mr = ri[7:0];
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    exp_t e;
    int   lat;
    int   bc;
    @(negedge clk);
    a     = ta;
    b     = tb;
    sgn   = ts;
    start = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.lat = (tb == 8'd0) ? 2 : BITS + 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("finished_cleared", finished, 1'b0);
    lat = 0;
    bc  = 0;
    while (!finished && lat < 40) begin
      if (busy) bc++;
      if (lat == 1 && tb != 8'd0) chk("quot_held", quot, prev_q);
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("busy_cycles", bc, e.lat - 1);
    chk("busy_after", busy, 1'b0);
    chk("quot", quot, e.q);
    chk("rem", rem, e.r);
    chk("divzero", divzero, e.dz);
    prev_q = quot;
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] rr;
    logic       rdz;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    int         seen;

    rst    = 1'b1;
    start  = 1'b0;
    sgn    = 1'b0;
    a      = '0;
    b      = '0;
    prev_q = '0;

    vecs[0] = '{a: 8'd100, b: 8'd7,   s: 1'b0, q: 8'd14,  r: 8'd2,   dz: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd0,   s: 1'b0, q: 8'hFF,  r: 8'd5,   dz: 1'b1};
`ifdef SHIFT_DIVIDER_SIGNED_EN
    vecs[2] = '{a: 8'hF9,  b: 8'h02,  s: 1'b1, q: 8'hFD,  r: 8'hFF,  dz: 1'b0};
    vecs[3] = '{a: 8'h80,  b: 8'hFF,  s: 1'b1, q: 8'h80,  r: 8'h00,  dz: 1'b0};
    vecs[7] = '{a: 8'h07,  b: 8'hF9,  s: 1'b1, q: 8'hFF,  r: 8'h00,  dz: 1'b0};
`else
    vecs[2] = '{a: 8'hF9,  b: 8'h02,  s: 1'b1, q: 8'h7C,  r: 8'h01,  dz: 1'b0};
    vecs[3] = '{a: 8'h80,  b: 8'hFF,  s: 1'b1, q: 8'h00,  r: 8'h80,  dz: 1'b0};
    vecs[7] = '{a: 8'h07,  b: 8'hF9,  s: 1'b1, q: 8'h00,  r: 8'h07,  dz: 1'b0};
`endif
    vecs[4] = '{a: 8'd255, b: 8'd1,   s: 1'b0, q: 8'd255, r: 8'd0,   dz: 1'b0};
    vecs[5] = '{a: 8'd0,   b: 8'd5,   s: 1'b0, q: 8'd0,   r: 8'd0,   dz: 1'b0};
    vecs[6] = '{a: 8'hFF,  b: 8'hFF,  s: 1'b0, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    vecs[8] = '{a: 8'hF9,  b: 8'h00,  s: 1'b1, q: 8'hFF,  r: 8'hF9,  dz: 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quot", quot, 8'd0);
    chk("rst_rem", rem, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_finished", finished, 1'b0);
    chk("rst_divzero", divzero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    for (int unsigned i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rq, rr, rdz);
      run_op(ra, rb, rs, rq, rr, rdz);
    end

    // Start 200/3, a second start mid-operation, then reset before completion.
    @(negedge clk);
    a     = 8'd200;
    b     = 8'd3;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a     = 8'd9;
    b     = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignores_start", busy, 1'b1);
    chk("finished_low_midop", finished, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_quot", quot, 8'd0);
    chk("abort_rem", rem, 8'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_finished", finished, 1'b0);
    chk("abort_divzero", divzero, 1'b0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (finished || busy) seen++;
    end
    chk("abort_no_result", seen, 0);
    prev_q = 8'd0;
    run_op(8'd9, 8'd9, 1'b0, 8'd1, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
